// File: rtl/mac_seq_ctrl.sv
// Command sequencer for an FP8 MAC cell: clears the accumulator, streams operand
// beats into the cell, waits for every result pulse (with timeout) and returns the final result.
module mac_seq_ctrl #(
  parameter int unsigned K_MAX   = 256,
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned LEN_W   = $clog2(K_MAX + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              cmd_mode_fp8,
  input  logic              cmd_bf16_en,
  input  logic              abort,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [7:0]        op_a,
  input  logic [7:0]        op_b,
  output logic [7:0]        mac_a,
  output logic [7:0]        mac_b,
  output logic              mac_valid_a,
  output logic              mac_valid_b,
  output logic              mac_acc_en,
  output logic              mac_acc_clear,
  output logic              mac_mode_fp8,
  output logic              mac_out_bf16_en,
  input  logic              mac_ready_a,
  input  logic              mac_ready_b,
  input  logic              mac_c_valid,
  input  logic [7:0]        mac_c_fp8,
  input  logic [15:0]       mac_c_bf16,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [7:0]        res_fp8,
  output logic [15:0]       res_bf16,
  output logic              res_err,
  output logic              busy
);

  localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_FEED   = 3'd2,
    S_DRAIN  = 3'd3,
    S_RESULT = 3'd4
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] issue_cnt;
  logic [LEN_W-1:0] done_cnt;
  logic [TMO_W-1:0] tmo_cnt;
  logic [LEN_W:0]   done_sum;
  logic             cmd_hs;
  logic             op_hs;
  logic             cap_en;
  logic             done_hit;

  assign cmd_hs   = cmd_valid & cmd_ready;
  assign op_hs    = op_valid & op_ready;
  assign cap_en   = mac_c_valid & ((state == S_CLEAR) | (state == S_FEED) | (state == S_DRAIN));
  // A pulse landing in the same cycle counts toward completion.
  assign done_sum = (LEN_W+1)'(done_cnt) + (LEN_W+1)'(mac_c_valid);
  assign done_hit = (done_sum == (LEN_W+1)'(len_q));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; abort overrides every other transition
  always_comb begin
    state_nxt = state;
    if (abort && (state != S_IDLE)) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:   if (cmd_valid) state_nxt = (cmd_len == '0) ? S_RESULT : S_CLEAR;
        S_CLEAR:  state_nxt = S_FEED;
        S_FEED:   if (op_hs && (issue_cnt == LEN_W'(1))) state_nxt = S_DRAIN;
        S_DRAIN: begin
          if (done_hit)                        state_nxt = S_RESULT;
          else if (tmo_cnt <= TMO_W'(1))       state_nxt = S_RESULT;
        end
        S_RESULT: if (res_ready) state_nxt = S_IDLE;
        default:  state_nxt = S_IDLE;
      endcase
    end
  end

  // State-decoded outputs
  always_comb begin
    cmd_ready     = (state == S_IDLE);
    busy          = (state != S_IDLE);
    mac_acc_clear = (state == S_CLEAR);
    res_valid     = (state == S_RESULT);
    op_ready      = (state == S_FEED) & mac_ready_a & mac_ready_b & (issue_cnt != '0) & ~abort;
  end

  // Datapath: operand issue, counters, result capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_q           <= '0;
      issue_cnt       <= '0;
      done_cnt        <= '0;
      tmo_cnt         <= '0;
      mac_a           <= '0;
      mac_b           <= '0;
      mac_valid_a     <= 1'b0;
      mac_valid_b     <= 1'b0;
      mac_acc_en      <= 1'b0;
      mac_mode_fp8    <= 1'b0;
      mac_out_bf16_en <= 1'b0;
      res_fp8         <= '0;
      res_bf16        <= '0;
      res_err         <= 1'b0;
    end else begin
      mac_valid_a <= op_hs;
      mac_valid_b <= op_hs;
      mac_acc_en  <= op_hs;
      if (op_hs) begin
        mac_a     <= op_a;
        mac_b     <= op_b;
        issue_cnt <= issue_cnt - LEN_W'(1);
      end

      if (cmd_hs) begin
        len_q           <= cmd_len;
        mac_mode_fp8    <= cmd_mode_fp8;
        mac_out_bf16_en <= cmd_bf16_en;
        res_fp8         <= '0;
        res_bf16        <= '0;
        res_err         <= 1'b0;
      end

      if (state == S_CLEAR) begin
        issue_cnt <= len_q;
        done_cnt  <= LEN_W'(mac_c_valid);
      end else if (cap_en) begin
        done_cnt  <= done_cnt + LEN_W'(1);
      end

      if (cap_en) begin
        res_fp8  <= mac_c_fp8;
        res_bf16 <= mac_c_bf16;
      end

      if ((state == S_FEED) && (state_nxt == S_DRAIN)) tmo_cnt <= TMO_W'(TIMEOUT);
      else if (state == S_DRAIN)                       tmo_cnt <= tmo_cnt - TMO_W'(1);

      // Timeout exit keeps whatever result was last captured
      if ((state == S_DRAIN) && (state_nxt == S_RESULT) && !done_hit) res_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Scoreboard bench for mac_seq_ctrl: directed commands with a behavioural MAC cell stub
// whose per-beat results are hand-computed FP8/BF16 partial sums.
module tb_mac_seq_ctrl;

  localparam int unsigned K_MAX   = 16;
  localparam int unsigned TIMEOUT = 12;
  localparam int unsigned LEN_W   = $clog2(K_MAX + 1);

  logic             clk = 1'b0;
  logic             rst;
  logic             cmd_valid, cmd_ready;
  logic [LEN_W-1:0] cmd_len;
  logic             cmd_mode_fp8, cmd_bf16_en, abort;
  logic             op_valid, op_ready;
  logic [7:0]       op_a, op_b, mac_a, mac_b;
  logic             mac_valid_a, mac_valid_b, mac_acc_en, mac_acc_clear;
  logic             mac_mode_fp8, mac_out_bf16_en;
  logic             mac_ready_a, mac_ready_b, mac_c_valid;
  logic [7:0]       mac_c_fp8;
  logic [15:0]      mac_c_bf16;
  logic             res_valid, res_ready;
  logic [7:0]       res_fp8;
  logic [15:0]      res_bf16;
  logic             res_err, busy;

  mac_seq_ctrl #(.K_MAX(K_MAX), .TIMEOUT(TIMEOUT), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len),
    .cmd_mode_fp8(cmd_mode_fp8), .cmd_bf16_en(cmd_bf16_en), .abort(abort),
    .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
    .mac_a(mac_a), .mac_b(mac_b), .mac_valid_a(mac_valid_a), .mac_valid_b(mac_valid_b),
    .mac_acc_en(mac_acc_en), .mac_acc_clear(mac_acc_clear),
    .mac_mode_fp8(mac_mode_fp8), .mac_out_bf16_en(mac_out_bf16_en),
    .mac_ready_a(mac_ready_a), .mac_ready_b(mac_ready_b), .mac_c_valid(mac_c_valid),
    .mac_c_fp8(mac_c_fp8), .mac_c_bf16(mac_c_bf16),
    .res_valid(res_valid), .res_ready(res_ready), .res_fp8(res_fp8), .res_bf16(res_bf16),
    .res_err(res_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  int clr_cnt = 0;
  int last_strobe_cyc = 0;

  logic [15:0] op_q[$];
  logic [24:0] res_q[$];

  logic [7:0]  tab_fp8[8];
  logic [15:0] tab_bf16[8];
  logic        suppress = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // MAC cell stub: result pulse two cycles after each acc_en, values from tab_*
  initial begin
    logic [1:0] pipe;
    logic       en_s, clr_s;
    int         beat_idx;
    pipe = '0; beat_idx = 0;
    mac_c_valid = 1'b0; mac_c_fp8 = '0; mac_c_bf16 = '0;
    forever begin
      @(negedge clk);
      en_s  = mac_acc_en;
      clr_s = mac_acc_clear;
      @(posedge clk); #1;
      if (clr_s) begin
        pipe = '0; beat_idx = 0; mac_c_valid = 1'b0;
      end else begin
        mac_c_valid = pipe[1] && !suppress;
        if (pipe[1]) begin
          mac_c_fp8  = tab_fp8[beat_idx % 8];
          mac_c_bf16 = tab_bf16[beat_idx % 8];
          beat_idx++;
        end
        pipe = {pipe[0], en_s};
      end
    end
  end

  // Monitor: MAC strobes and results against the scoreboard queues
  initial forever begin
    logic [15:0] eop;
    @(negedge clk);
    if (mac_acc_clear) clr_cnt++;
    if (mac_valid_a || mac_valid_b || mac_acc_en) begin
      if (op_q.size() == 0) begin
        chk("unexpected_strobe", 32'({mac_valid_a, mac_valid_b, mac_acc_en}), 32'd0);
      end else begin
        eop = op_q.pop_front();
        chk("mac_operands", 32'({mac_a, mac_b}), 32'(eop));
        chk("mac_strobes", 32'({mac_valid_a, mac_valid_b, mac_acc_en}), 32'h7);
        last_strobe_cyc = cyc;
      end
    end
    if (res_valid) begin
      if (res_q.size() == 0) begin
        chk("unexpected_res_valid", 32'(res_valid), 32'd0);
      end else begin
        chk("result", 32'({res_fp8, res_bf16, res_err}), 32'(res_q[0]));
        if (res_ready) void'(res_q.pop_front());
      end
    end
  end

  task automatic send_cmd(input int len, input logic mode, input logic bf);
    int n = 0;
    cmd_valid = 1'b1; cmd_len = LEN_W'(len); cmd_mode_fp8 = mode; cmd_bf16_en = bf;
    forever begin
      @(negedge clk);
      if (cmd_ready) break;
      if (++n > 100) begin chk("cmd_accept_timeout", 32'd0, 32'd1); break; end
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic send_op(input logic [7:0] a, input logic [7:0] b);
    int n = 0;
    op_valid = 1'b1; op_a = a; op_b = b;
    forever begin
      @(negedge clk);
      if (op_ready) begin op_q.push_back({a, b}); break; end
      if (++n > 100) begin chk("op_accept_timeout", 32'd0, 32'd1); break; end
    end
    @(posedge clk); #1;
    op_valid = 1'b0;
  endtask

  task automatic wait_result(output int at_cyc);
    int n = 0;
    at_cyc = 0;
    forever begin
      @(negedge clk);
      if (res_valid && res_ready) begin at_cyc = cyc; break; end
      if (++n > 200) begin chk("result_timeout", 32'd0, 32'd1); break; end
    end
    @(negedge clk);
    chk("back_to_idle", 32'({res_valid, busy, cmd_ready}), 32'b001);
    @(posedge clk); #1;
  endtask

  initial begin
    int rc, c0;
    rst = 1'b1; cmd_valid = 0; cmd_len = '0; cmd_mode_fp8 = 0; cmd_bf16_en = 0; abort = 0;
    op_valid = 0; op_a = '0; op_b = '0; mac_ready_a = 1; mac_ready_b = 1; res_ready = 1;
    for (int i = 0; i < 8; i++) begin tab_fp8[i] = '0; tab_bf16[i] = '0; end

    repeat (2) @(negedge clk);
    chk("rst_ctrl", 32'({cmd_ready, busy, res_valid, op_ready, mac_acc_clear}), 32'b10000);
    chk("rst_mac", 32'({mac_a, mac_b, mac_valid_a, mac_valid_b, mac_acc_en, mac_mode_fp8, mac_out_bf16_en}), 32'd0);
    chk("rst_res", 32'({res_fp8, res_bf16, res_err}), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Two beats: 1.0*2.0 + 1.0*1.0 = 3.0
    tab_fp8[0] = 8'h40; tab_bf16[0] = 16'h4000;
    tab_fp8[1] = 8'h44; tab_bf16[1] = 16'h4040;
    c0 = clr_cnt;
    res_q.push_back({8'h44, 16'h4040, 1'b0});
    send_cmd(2, 1'b0, 1'b1);
    @(negedge clk);
    chk("t1_mode_regs", 32'({mac_mode_fp8, mac_out_bf16_en}), 32'b01);
    send_op(8'h38, 8'h40);
    send_op(8'h38, 8'h38);
    wait_result(rc);
    chk("t1_clear_count", 32'(clr_cnt - c0), 32'd1);

    // Three beats with a 3-cycle mac_ready_a stall: 2.0, 3.0, 3.5
    tab_fp8[0] = 8'h40; tab_bf16[0] = 16'h4000;
    tab_fp8[1] = 8'h44; tab_bf16[1] = 16'h4040;
    tab_fp8[2] = 8'h46; tab_bf16[2] = 16'h4060;
    res_q.push_back({8'h46, 16'h4060, 1'b0});
    send_cmd(3, 1'b0, 1'b1);
    send_op(8'h40, 8'h38);
    mac_ready_a = 1'b0; op_valid = 1'b1; op_a = 8'h38; op_b = 8'h38;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t2_stall_op_ready", 32'(op_ready), 32'd0);
      @(posedge clk); #1;
    end
    mac_ready_a = 1'b1;
    send_op(8'h38, 8'h38);
    send_op(8'h30, 8'h38);
    wait_result(rc);

    // Zero-length command, result held while res_ready is low
    c0 = clr_cnt;
    res_ready = 1'b0;
    res_q.push_back({8'h00, 16'h0000, 1'b0});
    send_cmd(0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t3_hold", 32'({res_valid, cmd_ready, busy, mac_mode_fp8, mac_out_bf16_en}), 32'b10110);
    end
    @(posedge clk); #1;
    res_ready = 1'b1;
    wait_result(rc);
    chk("t3_clear_count", 32'(clr_cnt - c0), 32'd0);

    // Timeout: no result pulses at all
    suppress = 1'b1;
    res_q.push_back({8'h00, 16'h0000, 1'b1});
    send_cmd(2, 1'b0, 1'b1);
    send_op(8'h38, 8'h38);
    send_op(8'h38, 8'h38);
    wait_result(rc);
    chk("t4_timeout_latency", 32'(rc - last_strobe_cyc), 32'(TIMEOUT));
    suppress = 1'b0;

    // Abort after one of four beats, then a one-beat command: 2.0*2.0 = 4.0
    send_cmd(4, 1'b0, 1'b1);
    send_op(8'h38, 8'h38);
    abort = 1'b1; op_valid = 1'b1; op_a = 8'h11; op_b = 8'h22;
    @(negedge clk);
    chk("t5_abort_op_ready", 32'(op_ready), 32'd0);
    @(posedge clk); #1;
    abort = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t5_idle_after_abort", 32'({busy, cmd_ready, res_valid, op_ready}), 32'b0100);
    end
    @(posedge clk); #1;
    op_valid = 1'b0;
    tab_fp8[0] = 8'h48; tab_bf16[0] = 16'h4080;
    res_q.push_back({8'h48, 16'h4080, 1'b0});
    send_cmd(1, 1'b0, 1'b1);
    send_op(8'h40, 8'h40);
    wait_result(rc);

    // Reset in DRAIN before the result pulse arrives
    tab_fp8[0] = 8'h38; tab_bf16[0] = 16'h3f80;
    send_cmd(1, 1'b1, 1'b1);
    send_op(8'h38, 8'h38);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("t6_rst_ctrl", 32'({cmd_ready, busy, res_valid, mac_acc_clear}), 32'b1000);
    chk("t6_rst_mac", 32'({mac_a, mac_b, mac_valid_a, mac_valid_b, mac_acc_en, mac_mode_fp8, mac_out_bf16_en}), 32'd0);
    chk("t6_rst_res", 32'({res_fp8, res_bf16, res_err}), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t6_quiet_after_rst", 32'({busy, res_valid, cmd_ready}), 32'b001);
    end

    chk("op_queue_drained", 32'(op_q.size()), 32'd0);
    chk("res_queue_drained", 32'(res_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
